// File: rtl/seq_mult_3bit.sv
// Unsigned shift-and-add multiplier: one partial product per CALC cycle,
// W cycles per operation, registered 2W-bit product with a done pulse.
module seq_mult_3bit #(
  parameter int W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int SW = $clog2(W + 1);
  localparam logic [SW-1:0] LAST = SW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_p;
  logic [SW-1:0]  r_step;

  logic           w_load;
  logic           w_last;
  logic [2*W-1:0] w_addend;
  logic [2*W-1:0] w_sum;

  // New work is only accepted when no operation is computing.
  assign w_load = start &&
                  (r_state == IDLE || r_state == DONE);
  assign w_last = (r_state == CALC) && (r_step == LAST);

  assign w_addend = r_mplier[0] ?
                    ({{W{1'b0}}, r_mcand} << r_step) :
                    '0;
  assign w_sum    = r_acc + w_addend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = CALC;
      end
      CALC: begin
        if (r_step == LAST) w_next = DONE;
      end
      DONE: begin
        w_next = start ? CALC : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_step   <= '0;
      r_p      <= '0;
    end else if (w_load) begin
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= '0;
      r_step   <= '0;
    end else if (r_state == CALC) begin
      r_acc    <= w_sum;
      r_mplier <= r_mplier >> 1;
      r_step   <= r_step + SW'(1);
      if (w_last) r_p <= w_sum;
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign p    = r_p;

endmodule

// File: tb/tb_seq_mult_3bit.sv
// Directed bench for seq_mult_3bit (W=3): latency, pulses,
// back-to-back, reset abort and an exhaustive operand sweep.
module tb_seq_mult_3bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] a;
  logic [2:0] b;
  logic       busy;
  logic       done;
  logic [5:0] p;

  int n_chk;
  int n_err;

  seq_mult_3bit #(.W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts from IDLE, ends back in IDLE.
  task automatic run_op(input string tag,
                        input logic [2:0] ia,
                        input logic [2:0] ib,
                        input logic [5:0] ep);
    a = ia;
    b = ib;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 3'($urandom);
    b = 3'($urandom);
    chk({tag, " busy@k"}, 32'(busy), 1);
    chk({tag, " done@k"}, 32'(done), 0);
    tick();
    chk({tag, " done@k+1"}, 32'(done), 0);
    tick();
    chk({tag, " done@k+2"}, 32'(done), 0);
    tick();
    chk({tag, " done@k+3"}, 32'(done), 1);
    chk({tag, " busy@k+3"}, 32'(busy), 1);
    chk({tag, " p"}, 32'(p), 32'(ep));
    tick();
    chk({tag, " done@k+4"}, 32'(done), 0);
    chk({tag, " busy@k+4"}, 32'(busy), 0);
    chk({tag, " p held"}, 32'(p), 32'(ep));
  endtask

  logic [2:0] pa [3];
  logic [2:0] pb [3];
  logic [5:0] pp [3];

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset p", 32'(p), 0);

    // start during reset must be ignored
    start = 1'b1;
    a = 3'd7;
    b = 3'd7;
    tick();
    chk("start under rst busy", 32'(busy), 0);
    start = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle busy", 32'(busy), 0);

    run_op("7x7", 3'd7, 3'd7, 6'd49);
    run_op("0x5", 3'd0, 3'd5, 6'd0);
    run_op("5x0", 3'd5, 3'd0, 6'd0);
    run_op("5x3", 3'd5, 3'd3, 6'd15);

    // start held during CALC does not disturb the operation
    a = 3'd6;
    b = 3'd5;
    start = 1'b1;
    tick();
    a = 3'd1;
    b = 3'd1;
    tick();
    chk("calc-ign done@k+1", 32'(done), 0);
    tick();
    chk("calc-ign done@k+2", 32'(done), 0);
    chk("calc-ign busy@k+2", 32'(busy), 1);
    start = 1'b0;
    tick();
    chk("calc-ign done@k+3", 32'(done), 1);
    chk("calc-ign p", 32'(p), 30);
    tick();
    chk("calc-ign busy@k+4", 32'(busy), 0);
    chk("calc-ign done@k+4", 32'(done), 0);

    // start held continuously: one result every 4 cycles
    pa = '{3'd3, 3'd4, 3'd7};
    pb = '{3'd2, 3'd4, 3'd1};
    pp = '{6'd6, 6'd16, 6'd7};
    a = pa[0];
    b = pb[0];
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("b2b%0d done@acc", i), 32'(done), 0);
      chk($sformatf("b2b%0d busy@acc", i), 32'(busy), 1);
      if (i < 2) begin
        a = pa[i+1];
        b = pb[i+1];
      end else begin
        a = 3'd0;
        b = 3'd0;
      end
      tick();
      chk($sformatf("b2b%0d done@+1", i), 32'(done), 0);
      tick();
      chk($sformatf("b2b%0d done@+2", i), 32'(done), 0);
      if (i == 2) start = 1'b0;
      tick();
      chk($sformatf("b2b%0d done", i), 32'(done), 1);
      chk($sformatf("b2b%0d p", i), 32'(p), 32'(pp[i]));
    end
    tick();
    chk("b2b end busy", 32'(busy), 0);
    chk("b2b end done", 32'(done), 0);

    // reset mid-operation abandons the result
    a = 3'd7;
    b = 3'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort p", 32'(p), 0);
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("abort quiet%0d", i), 32'(done), 0);
      chk($sformatf("abort idle%0d", i), 32'(busy), 0);
    end
    run_op("2x3", 3'd2, 3'd3, 6'd6);

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        run_op($sformatf("sweep %0dx%0d", i, j),
               3'(i), 3'(j), 6'(i * j));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
